quad_enc_gen: RTL and testbench
===============================

QUAD_ENC_GEN -- requirements
Module: quad_enc_gen

Interface
REQ-001 The module SHALL have parameter CPR, default 2048, meaning encoder counts per revolution (quadrature edges, ≥4).
REQ-002 The module SHALL have parameter PER_W, default 16, meaning step-period field width.
REQ-003 The module SHALL have port clk  in  1  single system clock; all logic is rising-edge.
REQ-004 The module SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port enable  in  1  high lets steps occur; low freezes the period counter, phase and position.
REQ-006 The module SHALL have port cmd_valid  in  1  new velocity command offered.
REQ-007 The module SHALL have port cmd_ready  out  1  command slot free.
REQ-008 The module SHALL have port cmd_period  in  PER_W  clk cycles per quadrature count; 0 = stopped.
REQ-009 The module SHALL have port cmd_dir  in  1  1 = forward (A leads B), 0 = reverse.
REQ-010 The module SHALL have ports enc_a, enc_b, enc_z  out  1 each  emulated encoder channels, registered.
REQ-011 The module SHALL have port position  out  clog2(CPR)  current count, 0..CPR-1.
REQ-012 The module SHALL have port step_pulse  out  1  one-cycle strobe on every count.

Function
REQ-013 Forward phase sequence {A,B} SHALL be 00→10→11→01→00; reverse SHALL be the exact inverse.
REQ-014 The active period counter SHALL load active_period-1 and decrement while enable=1; at 0 it SHALL emit one step and reload.
REQ-015 Each step SHALL advance phase one position and update position by ±1 in the same cycle, with step_pulse high that cycle.
REQ-016 Forward CPR-1 SHALL wrap to 0; reverse 0 SHALL wrap to CPR-1.
REQ-017 enc_z SHALL be high for exactly the count interval in which position==0 entered via a step, and low otherwise.
REQ-018 active_period==0 SHALL produce no steps; outputs hold.
REQ-019 Handshake: transfer on cmd_valid && cmd_ready; cmd_ready SHALL drop the cycle after transfer and rise the cycle after the pending command is applied.
REQ-020 A pending command SHALL apply at the next step boundary, with the reload using the new period; if active_period==0 it SHALL apply the cycle after transfer, with the first step cmd_period cycles later.
REQ-021 A step and an apply coinciding SHALL take the step with the old direction; subsequent steps SHALL use the new one.
REQ-022 A direction reversal SHALL never skip or double a phase, so there is no illegal 00↔11 or 10↔01 transition.
REQ-023 enable=0 SHALL still accept and apply commands; the counter SHALL restart from the new period on the first enabled cycle.

Reset
REQ-024 On reset assertion, enc_a, enc_b, enc_z and step_pulse SHALL be 0, position SHALL be 0, active_period SHALL be 0, pending SHALL be empty and cmd_ready SHALL be 1, all asynchronously.
REQ-025 Reset mid-count SHALL discard any pending command; no step pulse SHALL be emitted in the release cycle.

Configuration
REQ-026 With QEG_INDEX_EN defined, enc_z SHALL follow REQ-017.
REQ-027 Without QEG_INDEX_EN, enc_z SHALL be tied 0 and no index logic SHALL be synthesized; all other behaviour SHALL be unchanged.

Structure
REQ-028 Package qeg_pkg SHALL hold the phase encoding constants (PH_00, PH_10, PH_11, PH_01) and the default CPR and PER_W values.
REQ-029 Sub-module qeg_rate_div SHALL contain the period counter: load, enable, tick output.
REQ-030 Phase, position and handshake logic SHALL stay in quad_enc_gen.

Verification
REQ-031 Reset, then cmd period=4 dir=1 -> first step 4 cycles after apply; {A,B} 10,11,01,00 at 4-cycle spacing; position 1,2,3,4.
REQ-032 CPR=8, forward period=2 for 8 steps -> position wraps 7→0; enc_z high exactly on the 0 interval (QEG_INDEX_EN) or always 0 (without it).
REQ-033 Reverse from position 0 -> position 7 (CPR=8), phase 00→01, enc_z low.
REQ-034 Running period=10; issue period=3 dir=0 mid-count -> cmd_ready low until the next step; the step after the change occurs 3 cycles later in reverse with a legal phase transition.
REQ-035 Command arriving on the same cycle as a step -> that step uses the old dir; the new dir applies from the next step.
REQ-036 Assert reset mid-period with a pending command -> all outputs 0 immediately; after release no steps occur until a new command is issued.

Source files
------------

// File: rtl/qeg_pkg.sv
// Shared constants for the quadrature encoder generator: the phase encoding,
// default configuration values and the phase sequencing helper.
package qeg_pkg;

  localparam int unsigned QEG_CPR_DEF   = 2048;
  localparam int unsigned QEG_PER_W_DEF = 16;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_10 = 2'b10,
    PH_11 = 2'b11,
    PH_01 = 2'b01
  } qeg_phase_e;

  // Forward runs 00->10->11->01->00; reverse is the exact inverse, so any
  // direction change still moves exactly one Gray step.
  function automatic qeg_phase_e next_phase(input qeg_phase_e ph, input logic fwd);
    qeg_phase_e nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = fwd ? PH_10 : PH_01;
      PH_10:   nxt = fwd ? PH_11 : PH_00;
      PH_11:   nxt = fwd ? PH_01 : PH_10;
      PH_01:   nxt = fwd ? PH_00 : PH_11;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/qeg_rate_div.sv
// Step-period counter: reloads to period-1, counts down while enabled and
// raises tick on the enabled cycle in which it reaches zero.
module qeg_rate_div #(
  parameter int unsigned PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [PER_W-1:0] period,
  input  logic [PER_W-1:0] load_period,
  output logic             tick
);

  logic [PER_W-1:0] cnt;

  assign tick = enable && (period != '0) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_period == '0) ? '0 : load_period - PER_W'(1);
    end else if (tick) begin
      cnt <= period - PER_W'(1);
    end else if (enable && (period != '0)) begin
      cnt <= cnt - PER_W'(1);
    end
  end

endmodule

// File: rtl/quad_enc_gen.sv
// Emulated incremental encoder: A/B quadrature, position count and optional
// index pulse (enabled with macro QEG_INDEX_EN) driven by velocity commands.
module quad_enc_gen
  import qeg_pkg::*;
#(
  parameter int unsigned CPR   = QEG_CPR_DEF,
  parameter int unsigned PER_W = QEG_PER_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [PER_W-1:0]        cmd_period,
  input  logic                    cmd_dir,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    enc_z,
  output logic [$clog2(CPR)-1:0]  position,
  output logic                    step_pulse
);

  localparam int unsigned POS_W = $clog2(CPR);

  logic [PER_W-1:0] active_period;
  logic [PER_W-1:0] pend_period;
  logic             active_dir;
  logic             pend_dir;
  qeg_phase_e       phase;
  logic             tick;
  logic             xfer;
  logic             apply;
  logic [POS_W-1:0] pos_next;

  // The pending slot is full exactly when cmd_ready is low. A stopped or
  // disabled generator has no step boundary to wait for, so it applies at once.
  assign xfer  = cmd_valid && cmd_ready;
  assign apply = !cmd_ready && (tick || (active_period == '0) || !enable);

  qeg_rate_div #(
    .PER_W (PER_W)
  ) u_rate_div (
    .clk         (clk),
    .rst         (reset),
    .enable      (enable),
    .load        (apply),
    .period      (active_period),
    .load_period (pend_period),
    .tick        (tick)
  );

  always_comb begin
    pos_next = position;
    if (active_dir) begin
      pos_next = (position == POS_W'(CPR - 1)) ? '0 : position + POS_W'(1);
    end else begin
      pos_next = (position == '0) ? POS_W'(CPR - 1) : position - POS_W'(1);
    end
  end

  assign {enc_a, enc_b} = phase;

  // A step coinciding with an apply still uses active_dir, which only takes
  // the new value after this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_period <= '0;
      active_dir    <= 1'b0;
      pend_period   <= '0;
      pend_dir      <= 1'b0;
      cmd_ready     <= 1'b1;
      phase         <= PH_00;
      position      <= '0;
      step_pulse    <= 1'b0;
    end else begin
      step_pulse <= tick;
      if (xfer) begin
        pend_period <= cmd_period;
        pend_dir    <= cmd_dir;
        cmd_ready   <= 1'b0;
      end
      if (apply) begin
        active_period <= pend_period;
        active_dir    <= pend_dir;
        cmd_ready     <= 1'b1;
      end
      if (tick) begin
        phase    <= next_phase(phase, active_dir);
        position <= pos_next;
      end
    end
  end

`ifdef QEG_INDEX_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_z <= 1'b0;
    end else if (tick) begin
      enc_z <= (pos_next == '0);
    end
  end
`else
  assign enc_z = 1'b0;
`endif

endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed bench for quad_enc_gen with CPR=8; index expectations follow
// whether QEG_INDEX_EN is defined.
module tb_quad_enc_gen;

  localparam int unsigned CPR   = 8;
  localparam int unsigned PER_W = 16;
`ifdef QEG_INDEX_EN
  localparam logic ZE = 1'b1;
`else
  localparam logic ZE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [PER_W-1:0] cmd_period = '0;
  logic             cmd_dir = 1'b0;
  logic             enc_a, enc_b, enc_z;
  logic [2:0]       position;
  logic             step_pulse;

  int checks = 0;
  int errors = 0;
  logic [1:0] cur_ab  = 2'b00;
  logic [2:0] cur_pos = 3'd0;
  logic       cur_z   = 1'b0;

  quad_enc_gen #(
    .CPR   (CPR),
    .PER_W (PER_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_period (cmd_period),
    .cmd_dir    (cmd_dir),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_z      (enc_z),
    .position   (position),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_chk(input string tag);
    chk({tag, "_nostep"}, 32'(step_pulse), 0);
    chk({tag, "_ab"}, 32'({enc_a, enc_b}), 32'(cur_ab));
    chk({tag, "_pos"}, 32'(position), 32'(cur_pos));
    chk({tag, "_z"}, 32'(enc_z), 32'(cur_z));
  endtask

  task automatic idle(input int n, input logic rdy, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      hold_chk(tag);
      chk({tag, "_rdy"}, 32'(cmd_ready), 32'(rdy));
    end
  endtask

  // gap edges from now; the last one must carry the step
  task automatic run_step(input int gap, input logic [1:0] ab, input logic [2:0] pos,
                          input logic z, input string tag);
    for (int i = 0; i < gap - 1; i++) begin
      @(posedge clk); #1;
      hold_chk(tag);
    end
    @(posedge clk); #1;
    cur_ab = ab; cur_pos = pos; cur_z = z;
    chk({tag, "_step"}, 32'(step_pulse), 1);
    chk({tag, "_ab"}, 32'({enc_a, enc_b}), 32'(ab));
    chk({tag, "_pos"}, 32'(position), 32'(pos));
    chk({tag, "_z"}, 32'(enc_z), 32'(z));
  endtask

  task automatic send(input int p, input logic d, input string tag);
    cmd_period = PER_W'(p);
    cmd_dir    = d;
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    chk({tag, "_rdy_drop"}, 32'(cmd_ready), 0);
  endtask

  initial begin
    // asynchronous reset, checked before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_ab", 32'({enc_a, enc_b}), 0);
    chk("rst_z", 32'(enc_z), 0);
    chk("rst_step", 32'(step_pulse), 0);
    chk("rst_pos", 32'(position), 0);
    chk("rst_rdy", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(3, 1'b1, "stopped");

    // forward period 4: apply one edge after transfer, step 4 after apply
    send(4, 1'b1, "fwd4");
    run_step(5, 2'b10, 3'd1, 1'b0, "fwd4_s1");
    chk("fwd4_rdy_back", 32'(cmd_ready), 1);
    run_step(4, 2'b11, 3'd2, 1'b0, "fwd4_s2");
    run_step(4, 2'b01, 3'd3, 1'b0, "fwd4_s3");
    run_step(4, 2'b00, 3'd4, 1'b0, "fwd4_s4");

    // period 2 forward, applied at the next step, wrap 7->0 with index
    send(2, 1'b1, "fwd2");
    run_step(3, 2'b10, 3'd5, 1'b0, "fwd2_s5");
    chk("fwd2_rdy_back", 32'(cmd_ready), 1);
    run_step(2, 2'b11, 3'd6, 1'b0, "fwd2_s6");
    run_step(2, 2'b01, 3'd7, 1'b0, "fwd2_s7");
    run_step(2, 2'b00, 3'd0, ZE,   "fwd2_wrap0");
    run_step(2, 2'b10, 3'd1, 1'b0, "fwd2_s1");
    run_step(2, 2'b11, 3'd2, 1'b0, "fwd2_s2");
    run_step(2, 2'b01, 3'd3, 1'b0, "fwd2_s3");
    run_step(2, 2'b00, 3'd4, 1'b0, "fwd2_s4");
    run_step(2, 2'b10, 3'd5, 1'b0, "fwd2_s5b");
    run_step(2, 2'b11, 3'd6, 1'b0, "fwd2_s6b");
    run_step(2, 2'b01, 3'd7, 1'b0, "fwd2_s7b");
    run_step(2, 2'b00, 3'd0, ZE,   "fwd2_wrap0b");

    // reverse from 0 while disabled: command applies, counter restarts on enable
    enable = 1'b0;
    send(2, 1'b0, "rev2");
    idle(1, 1'b1, "rev2_dis");
    enable = 1'b1;
    run_step(2, 2'b01, 3'd7, 1'b0, "rev2_wrap7");
    run_step(2, 2'b11, 3'd6, 1'b0, "rev2_s6");

    // period 10 forward, then period 3 reverse issued mid-count
    send(10, 1'b1, "fwd10");
    run_step(1, 2'b10, 3'd5, 1'b0, "fwd10_oldrev");
    run_step(10, 2'b11, 3'd6, 1'b0, "fwd10_s6");
    idle(3, 1'b1, "fwd10_mid");
    send(3, 1'b0, "rev3");
    idle(5, 1'b0, "rev3_wait");
    run_step(1, 2'b01, 3'd7, 1'b0, "rev3_oldfwd");
    chk("rev3_rdy_back", 32'(cmd_ready), 1);
    run_step(3, 2'b11, 3'd6, 1'b0, "rev3_s6");

    // command transferred on the same edge as a step
    idle(2, 1'b1, "coin_pre");
    send(2, 1'b1, "coin");
    cur_ab = 2'b10; cur_pos = 3'd5;
    chk("coin_step", 32'(step_pulse), 1);
    chk("coin_ab", 32'({enc_a, enc_b}), 32'(2'b10));
    chk("coin_pos", 32'(position), 5);
    run_step(3, 2'b00, 3'd4, 1'b0, "coin_apply_old");
    run_step(2, 2'b10, 3'd5, 1'b0, "coin_newdir");

    // reset mid-period with a pending command
    send(6, 1'b0, "pend");
    reset = 1'b1;
    #2;
    chk("mrst_ab", 32'({enc_a, enc_b}), 0);
    chk("mrst_z", 32'(enc_z), 0);
    chk("mrst_step", 32'(step_pulse), 0);
    chk("mrst_pos", 32'(position), 0);
    chk("mrst_rdy", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    cur_ab = 2'b00; cur_pos = 3'd0; cur_z = 1'b0;
    idle(8, 1'b1, "post_rst");
    send(3, 1'b1, "restart");
    run_step(4, 2'b10, 3'd1, 1'b0, "restart_s1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
